// File: rtl/alu_collect_pkg.sv
// Shared types, command codes and command-classification helpers for the ALU operand collector.
package alu_collect_pkg;

    localparam int unsigned CMD_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, ISSUE} state_e;
    typedef enum logic [1:0] {OK, TIMEOUT, NO_OPERAND, BAD_CMD} err_e;

    // MODE=1 (arithmetic)
    localparam logic [CMD_W-1:0] CMD_ADD       = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SUB       = 4'd1;
    localparam logic [CMD_W-1:0] CMD_ADD_CIN   = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SUB_CIN   = 4'd3;
    localparam logic [CMD_W-1:0] CMD_INC_A     = 4'd4;
    localparam logic [CMD_W-1:0] CMD_DEC_A     = 4'd5;
    localparam logic [CMD_W-1:0] CMD_INC_B     = 4'd6;
    localparam logic [CMD_W-1:0] CMD_DEC_B     = 4'd7;
    localparam logic [CMD_W-1:0] CMD_CMP       = 4'd8;
    localparam logic [CMD_W-1:0] CMD_MUL_INC   = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MUL_SHIFT = 4'd10;

    // MODE=0 (logical)
    localparam logic [CMD_W-1:0] CMD_AND       = 4'd0;
    localparam logic [CMD_W-1:0] CMD_NAND      = 4'd1;
    localparam logic [CMD_W-1:0] CMD_OR        = 4'd2;
    localparam logic [CMD_W-1:0] CMD_NOR       = 4'd3;
    localparam logic [CMD_W-1:0] CMD_XOR       = 4'd4;
    localparam logic [CMD_W-1:0] CMD_XNOR      = 4'd5;
    localparam logic [CMD_W-1:0] CMD_NOT_A     = 4'd6;
    localparam logic [CMD_W-1:0] CMD_NOT_B     = 4'd7;
    localparam logic [CMD_W-1:0] CMD_SHR1_A    = 4'd8;
    localparam logic [CMD_W-1:0] CMD_SHL1_A    = 4'd9;
    localparam logic [CMD_W-1:0] CMD_SHR1_B    = 4'd10;
    localparam logic [CMD_W-1:0] CMD_SHL1_B    = 4'd11;
    localparam logic [CMD_W-1:0] CMD_ROL_A_B   = 4'd12;
    localparam logic [CMD_W-1:0] CMD_ROR_A_B   = 4'd13;

    function automatic logic cmd_in_range(logic mode, logic [CMD_W-1:0] cmd);
        return mode ? (cmd <= CMD_MUL_SHIFT) : (cmd <= CMD_ROR_A_B);
    endfunction

    function automatic logic is_two_op(logic mode, logic [CMD_W-1:0] cmd);
        if (mode) begin
            return cmd inside {CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN,
                               CMD_CMP, CMD_MUL_INC, CMD_MUL_SHIFT};
        end
        return cmd inside {CMD_AND, CMD_NAND, CMD_OR, CMD_NOR, CMD_XOR, CMD_XNOR,
                           CMD_ROL_A_B, CMD_ROR_A_B};
    endfunction

    // Single-operand commands: 1 when the command consumes OPA, 0 when it consumes OPB.
    function automatic logic needs_a(logic mode, logic [CMD_W-1:0] cmd);
        if (mode) begin
            return cmd inside {CMD_INC_A, CMD_DEC_A};
        end
        return cmd inside {CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A};
    endfunction

endpackage

// File: rtl/alu_operand_collector_timeout.sv
// Second-operand wait counter: cleared outside the wait window, expired at TIMEOUT-1.
module alu_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects OPA/OPB (possibly in separate cycles) into one ALU request issued over valid/ready.
// Optional saturating statistics counters are built when ALU_COLLECT_STATS_EN is defined.
module alu_operand_collector
    import alu_collect_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic                 in_ready,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [WIDTH-1:0]     iss_opa,
    output logic [WIDTH-1:0]     iss_opb,
    output logic [CMD_WIDTH-1:0] iss_cmd,
    output logic                 iss_mode,
    output logic                 iss_cin,
    output logic [1:0]           iss_err,
    output logic [15:0]          stat_timeouts,
    output logic [15:0]          stat_issues
);

    state_e               state_q, state_d;
    err_e                 err_q, err_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 mode_q, mode_d, cin_q, cin_d;
    logic                 live_q;
    logic                 accept, go_wait, waiting, expired, handshake;

    // live_q keeps in_ready low until the first clock after reset release.
    assign in_ready  = live_q && (state_q != ISSUE);
    assign accept    = CE && in_ready;
    assign waiting   = (state_q == WAIT_A) || (state_q == WAIT_B);
    assign handshake = (state_q == ISSUE) && iss_ready;

    alu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (!(waiting || go_wait)),
        .enable  (waiting || go_wait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        go_wait = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d   = CMD;
                    mode_d  = MODE;
                    cin_d   = CIN;
                    opa_d   = INP_VALID[0] ? OPA : '0;
                    opb_d   = INP_VALID[1] ? OPB : '0;
                    state_d = ISSUE;
                    err_d   = OK;
                    if (!cmd_in_range(MODE, CMD)) begin
                        err_d = BAD_CMD;
                    end else if (INP_VALID == 2'b00) begin
                        err_d = NO_OPERAND;
                    end else if (INP_VALID != 2'b11) begin
                        if (is_two_op(MODE, CMD)) begin
                            go_wait = 1'b1;
                            state_d = INP_VALID[0] ? WAIT_B : WAIT_A;
                        end else if (needs_a(MODE, CMD) != INP_VALID[0]) begin
                            err_d = NO_OPERAND;
                        end
                    end
                end
            end
            WAIT_A: begin
                if (accept && INP_VALID[0]) begin
                    opa_d   = OPA;
                    state_d = ISSUE;
                end else if (expired) begin
                    err_d   = alu_collect_pkg::TIMEOUT;
                    state_d = ISSUE;
                end
            end
            WAIT_B: begin
                if (accept && INP_VALID[1]) begin
                    opb_d   = OPB;
                    state_d = ISSUE;
                end else if (expired) begin
                    err_d   = alu_collect_pkg::TIMEOUT;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (iss_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            err_q   <= OK;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            live_q  <= 1'b1;
        end
    end

    assign iss_valid = (state_q == ISSUE);
    assign iss_opa   = opa_q;
    assign iss_opb   = opb_q;
    assign iss_cmd   = cmd_q;
    assign iss_mode  = mode_q;
    assign iss_cin   = cin_q;
    assign iss_err   = err_q;

`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] stat_timeouts_q, stat_issues_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_timeouts_q <= '0;
            stat_issues_q   <= '0;
        end else if (handshake) begin
            if (stat_issues_q != 16'hFFFF) begin
                stat_issues_q <= stat_issues_q + 16'd1;
            end
            if ((err_q == alu_collect_pkg::TIMEOUT) && (stat_timeouts_q != 16'hFFFF)) begin
                stat_timeouts_q <= stat_timeouts_q + 16'd1;
            end
        end
    end

    assign stat_timeouts = stat_timeouts_q;
    assign stat_issues   = stat_issues_q;
`else
    assign stat_timeouts = '0;
    assign stat_issues   = '0;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Randomized self-checking bench for alu_operand_collector against a transaction-level model.
module tb_alu_operand_collector;

    localparam int TMO = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CE, MODE, CIN, iss_ready;
    logic [3:0] CMD;
    logic [1:0] INP_VALID;
    logic [7:0] OPA, OPB;
    logic       in_ready, iss_valid, iss_mode, iss_cin;
    logic [7:0] iss_opa, iss_opb;
    logic [3:0] iss_cmd;
    logic [1:0] iss_err;
    logic [15:0] stat_timeouts, stat_issues;

    int n_checks = 0;
    int n_errors = 0;
    int m_issues = 0;
    int m_timeouts = 0;

    alu_operand_collector dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .CE            (CE),
        .MODE          (MODE),
        .CMD           (CMD),
        .INP_VALID     (INP_VALID),
        .OPA           (OPA),
        .OPB           (OPB),
        .CIN           (CIN),
        .in_ready      (in_ready),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_opa       (iss_opa),
        .iss_opb       (iss_opb),
        .iss_cmd       (iss_cmd),
        .iss_mode      (iss_mode),
        .iss_cin       (iss_cin),
        .iss_err       (iss_err),
        .stat_timeouts (stat_timeouts),
        .stat_issues   (stat_issues)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_stats();
`ifdef ALU_COLLECT_STATS_EN
        check("stat_issues", stat_issues, m_issues);
        check("stat_timeouts", stat_timeouts, m_timeouts);
`else
        check("stat_issues", stat_issues, 0);
        check("stat_timeouts", stat_timeouts, 0);
`endif
    endtask

    // Command classification written straight from the opcode lists.
    function automatic bit tb_in_range(logic m, logic [3:0] c);
        return m ? (c <= 4'd10) : (c <= 4'd13);
    endfunction

    function automatic bit tb_two_op(logic m, logic [3:0] c);
        if (m) return (c <= 4'd3) || (c >= 4'd8 && c <= 4'd10);
        return (c <= 4'd5) || (c == 4'd12) || (c == 4'd13);
    endfunction

    function automatic bit tb_a_only(logic m, logic [3:0] c);
        if (m) return (c == 4'd4) || (c == 4'd5);
        return (c == 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

    task automatic junk_inputs(input bit ce_any);
        CE        = ce_any ? 1'($urandom_range(0, 1)) : 1'b1;
        INP_VALID = 2'($urandom);
        MODE      = 1'($urandom);
        CMD       = 4'($urandom);
        CIN       = 1'($urandom);
        OPA       = 8'($urandom);
        OPB       = 8'($urandom);
    endtask

    // One complete transaction: capture, optional late operand at wait count `delay`
    // (>= TMO means never), `stall` cycles of back-pressure, then the handshake.
    task automatic run_txn(input logic m, input logic [3:0] c, input logic ci, input logic [1:0] iv,
                           input logic [7:0] a, input logic [7:0] b, input int delay,
                           input logic [7:0] late, input int stall);
        logic [7:0] ea, eb;
        logic [1:0] eerr;
        int         e_edge;
        bit         waits;
        ea    = iv[0] ? a : 8'h00;
        eb    = iv[1] ? b : 8'h00;
        waits = 1'b0;
        eerr  = 2'd0;
        if (!tb_in_range(m, c))      eerr = 2'd3;
        else if (iv == 2'b00)        eerr = 2'd2;
        else if (iv == 2'b11)        eerr = 2'd0;
        else if (tb_two_op(m, c))    waits = 1'b1;
        else if (tb_a_only(m, c) != iv[0]) eerr = 2'd2;
        e_edge = 1;
        if (waits) begin
            if (delay < TMO) begin
                e_edge = delay + 1;
            end else begin
                e_edge = TMO;
                eerr   = 2'd1;
            end
        end

        CE = 1'b1; MODE = m; CMD = c; CIN = ci; INP_VALID = iv; OPA = a; OPB = b;
        for (int e = 1; e <= e_edge; e++) begin
            if (e > 1) begin
                if (e - 1 == delay) begin
                    bit both;
                    both = 1'($urandom_range(0, 1));
                    junk_inputs(1'b0);
                    CE = 1'b1;
                    if (iv == 2'b01) begin
                        INP_VALID = both ? 2'b11 : 2'b10;
                        OPB = late;
                        eb  = late;
                    end else begin
                        INP_VALID = both ? 2'b11 : 2'b01;
                        OPA = late;
                        ea  = late;
                    end
                end else begin
                    junk_inputs(1'b1);
                    if (CE) INP_VALID = 2'b00;
                end
            end
            tick();
            check("iss_valid_timing", iss_valid, (e == e_edge));
        end

        for (int s = 0; s <= stall; s++) begin
            check("iss_opa", iss_opa, ea);
            check("iss_opb", iss_opb, eb);
            check("iss_cmd", iss_cmd, c);
            check("iss_mode", iss_mode, m);
            check("iss_cin", iss_cin, ci);
            check("iss_err", iss_err, eerr);
            check("in_ready_issue", in_ready, 0);
            if (s < stall) begin
                iss_ready = 1'b0;
                junk_inputs(1'b0);
                tick();
                check("iss_valid_stall", iss_valid, 1);
            end
        end
        iss_ready = 1'b1;
        junk_inputs(1'b0);
        tick();
        m_issues++;
        if (eerr == 2'd1) m_timeouts++;
        CE = 1'b0;
        INP_VALID = 2'b00;
        check("iss_valid_after_hs", iss_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
        check_stats();
    endtask

    initial begin
        RESET = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0;
        OPA = '0; OPB = '0; CIN = 1'b0; iss_ready = 1'b0;
        repeat (2) tick();
        check("rst_iss_valid", iss_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_iss_opa", iss_opa, 0);
        check("rst_iss_err", iss_err, 0);
        check_stats();
        RESET = 1'b0;
        tick();
        check("in_ready_after_release", in_ready, 1);
        check("iss_valid_idle", iss_valid, 0);

        // Both operands together.
        run_txn(1'b1, 4'd0, 1'b0, 2'b11, 8'h12, 8'h34, 99, 8'h00, 0);
        // OPA first, OPB five cycles later.
        run_txn(1'b1, 4'd0, 1'b1, 2'b01, 8'h05, 8'hEE, 5, 8'h03, 0);
        // Timeout with only OPB.
        run_txn(1'b0, 4'd0, 1'b0, 2'b10, 8'hAA, 8'h5C, 99, 8'h00, 0);
        // Operand on the last wait cycle beats the timeout.
        run_txn(1'b1, 4'd8, 1'b0, 2'b10, 8'h11, 8'h22, TMO - 1, 8'h9D, 1);
        // Bad command and missing operands.
        run_txn(1'b0, 4'd14, 1'b0, 2'b11, 8'h01, 8'h02, 99, 8'h00, 0);
        run_txn(1'b1, 4'd11, 1'b1, 2'b01, 8'h01, 8'h02, 99, 8'h00, 0);
        run_txn(1'b1, 4'd2, 1'b1, 2'b00, 8'h01, 8'h02, 99, 8'h00, 0);
        run_txn(1'b1, 4'd6, 1'b0, 2'b01, 8'h41, 8'h42, 99, 8'h00, 0);
        run_txn(1'b0, 4'd9, 1'b0, 2'b01, 8'h43, 8'h44, 99, 8'h00, 0);
        // Back-pressure for four cycles.
        run_txn(1'b0, 4'd4, 1'b1, 2'b11, 8'hC3, 8'h3C, 99, 8'h00, 4);

        for (int i = 0; i < 300; i++) begin
            run_txn(1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
                    8'($urandom), $urandom_range(1, 20), 8'($urandom), $urandom_range(0, 3));
        end

        // Reset while waiting for OPB at cnt=7.
        CE = 1'b1; MODE = 1'b1; CMD = 4'd0; CIN = 1'b0; INP_VALID = 2'b01; OPA = 8'h77;
        tick();
        CE = 1'b0; INP_VALID = 2'b00;
        repeat (6) tick();
        RESET = 1'b1;
        #1;
        m_issues = 0;
        m_timeouts = 0;
        check("midrst_iss_valid", iss_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check_stats();
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_no_issue", iss_valid, 0);
        end
        check("post_rst_in_ready", in_ready, 1);
        run_txn(1'b0, 4'd13, 1'b1, 2'b10, 8'h00, 8'h81, 3, 8'h18, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
